// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 multiplier: radix-2 shift-add significand product, one-cycle round/pack, valid/ready on both sides.
// NaN/Inf/zero operands bypass the datapath and complete on the cycle after accept.
module fp_mul_iter #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10,
  parameter int BIAS  = (1 << (EXPW-1)) - 1,
  parameter int WIDTH = 1 + EXPW + FRACW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rm,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int PW = 2*FRACW + 2;
  localparam int EW = EXPW + 2;
  localparam int CW = $clog2(FRACW + 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXPW) - 1);
  localparam logic        [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              sign_q, rm_q;
  logic [EXPW-1:0]   ea_q, eb_q;
  logic [PW-1:0]     mcand, prod;
  logic [FRACW:0]    mplier;

  // Operand decode for the accept cycle
  logic [EXPW-1:0]  a_exp, b_exp;
  logic [FRACW-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn_in;
  assign a_exp  = a[WIDTH-2 -: EXPW];
  assign b_exp  = b[WIDTH-2 -: EXPW];
  assign a_frac = a[FRACW-1:0];
  assign b_frac = b[FRACW-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_snan = a_nan && !a_frac[FRACW-1];
  assign b_snan = b_nan && !b_frac[FRACW-1];
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
  assign a_zero = !(|a_exp) && !(|a_frac);
  assign b_zero = !(|b_exp) && !(|b_frac);
  assign sgn_in = a[WIDTH-1] ^ b[WIDTH-1];

  logic             sp_hit;
  logic [WIDTH-1:0] sp_res;
  logic [3:0]       sp_flags;

  always_comb begin
    sp_hit   = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    sp_res   = {sgn_in, {(WIDTH-1){1'b0}}};
    sp_flags = 4'b0000;
    if (a_nan || b_nan) begin
      sp_res   = QNAN;
      sp_flags = {a_snan || b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      sp_res   = QNAN;
      sp_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      sp_res   = {sgn_in, {EXPW{1'b1}}, {FRACW{1'b0}}};
    end
  end

  // Normalize / denormalize / round / pack from the finished product
  logic [PW-1:0]          m;
  logic signed [EW-1:0]   e, exp_pre, exp_r;
  logic                   sticky_sh, tiny, guard, rnd, sticky, lsb, inexact, up, ovf;
  logic [FRACW+1:0]       sum;
  logic [FRACW-1:0]       frac_r;
  logic [WIDTH-1:0]       rnd_res;
  logic [3:0]             rnd_flags;

  always_comb begin
    m = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    e = $signed({2'b00, ea_q} + {2'b00, eb_q} - BIAS_E + EW'(prod[PW-1]));
    sticky_sh = 1'b0;
    for (int i = 0; i < PW; i++) begin
      if (!m[PW-1] && e > E_ONE) begin
        m = {m[PW-2:0], 1'b0};
        e = e - E_ONE;
      end
    end
    for (int i = 0; i <= PW; i++) begin
      if (e < E_ONE) begin
        sticky_sh = sticky_sh | m[0];
        m = {1'b0, m[PW-1:1]};
        e = e + E_ONE;
      end
    end
    tiny    = !m[PW-1];
    exp_pre = tiny ? '0 : e;
    lsb     = m[PW-1-FRACW];
    guard   = m[PW-2-FRACW];
    rnd     = m[PW-3-FRACW];
    sticky  = (|m[PW-4-FRACW:0]) | sticky_sh;
    inexact = guard | rnd | sticky;
    up      = !rm_q && guard && (rnd || sticky || lsb);
    sum     = {1'b0, m[PW-1 -: FRACW+1]} + {{(FRACW+1){1'b0}}, up};
    if (sum[FRACW+1]) begin
      exp_r  = exp_pre + E_ONE;
      frac_r = sum[FRACW:1];
    end else begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal
      exp_r  = sum[FRACW] ? (tiny ? E_ONE : exp_pre) : '0;
      frac_r = sum[FRACW-1:0];
    end
    ovf = exp_r >= E_MAX;
    if (ovf) begin
      rnd_res   = rm_q ? {sign_q, {(EXPW-1){1'b1}}, 1'b0, {FRACW{1'b1}}}
                       : {sign_q, {EXPW{1'b1}}, {FRACW{1'b0}}};
      rnd_flags = 4'b0101;
    end else begin
      rnd_res   = {sign_q, exp_r[EXPW-1:0], frac_r};
      rnd_flags = {2'b00, tiny && inexact, inexact};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      result   <= '0;
      flags    <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      rm_q     <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid && inReady) begin
            inReady <= 1'b0;
            sign_q  <= sgn_in;
            rm_q    <= rm;
            ea_q    <= (|a_exp) ? a_exp : EXPW'(1);
            eb_q    <= (|b_exp) ? b_exp : EXPW'(1);
            mcand   <= PW'({|a_exp, a_frac});
            mplier  <= {|b_exp, b_frac};
            prod    <= '0;
            cnt     <= '0;
            if (sp_hit) begin
              result   <= sp_res;
              flags    <= sp_flags;
              outValid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= {mcand[PW-2:0], 1'b0};
          mplier <= {1'b0, mplier[FRACW:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(FRACW)) state <= ROUND;
        end
        ROUND: begin
          result   <= rnd_res;
          flags    <= rnd_flags;
          outValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Scoreboard bench for fp_mul_iter (fp16): expectations queued at issue, compared when the result handshakes.
module tb_fp_mul_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] a = '0, b = '0;
  logic        rm = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_res_q[$];
  logic [3:0]  exp_flg_q[$];
  string       exp_tag_q[$];

  fp_mul_iter dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .a(a), .b(b), .rm(rm),
    .outValid(outValid), .outReady(outReady),
    .result(result), .flags(flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  // Result-side monitor: every output handshake must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && outValid && outReady) begin
      if (exp_res_q.size() == 0) begin
        check("spurious_out", 32'(result), 32'hFFFF_FFFF);
      end else begin
        string t;
        logic [15:0] er;
        logic [3:0]  ef;
        t  = exp_tag_q.pop_front();
        er = exp_res_q.pop_front();
        ef = exp_flg_q.pop_front();
        check({t, "_res"}, 32'(result), 32'(er));
        check({t, "_flags"}, 32'(flags), 32'(ef));
      end
    end
  end

  task automatic push_exp(input string tag, input logic [15:0] res, input logic [3:0] flg);
    exp_tag_q.push_back(tag);
    exp_res_q.push_back(res);
    exp_flg_q.push_back(flg);
  endtask

  // Called at a negedge; returns at accept edge + 1 with inputs scrambled
  task automatic issue(input string tag, input logic [15:0] oa, ob, input logic orm,
                       input logic [15:0] res, input logic [3:0] flg);
    int n;
    push_exp(tag, res, flg);
    a = oa; b = ob; rm = orm; inValid = 1'b1;
    n = 0;
    while (!inReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!inReady) check({tag, "_accept_timeout"}, 32'(inReady), 32'd1);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); rm = 1'($urandom);
  endtask

  task automatic wait_out(input string tag, input int lat_want);
    int lat;
    lat = 1;
    while (!outValid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!outValid) check({tag, "_out_timeout"}, 32'(outValid), 32'd1);
    else check({tag, "_latency"}, 32'(lat), 32'(lat_want));
  endtask

  task automatic run_op(input string tag, input logic [15:0] oa, ob, input logic orm,
                        input logic [15:0] res, input logic [3:0] flg, input int lat);
    issue(tag, oa, ob, orm, res, flg);
    wait_out(tag, lat);
    @(posedge clock);
    #1;
    @(negedge clock);
  endtask

  initial begin
    #2 reset = 1'b1;
    #5;
    check("rst_inReady",  32'(inReady),  32'd1);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_result",   32'(result),   32'd0);
    check("rst_flags",    32'(flags),    32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_1p5x2",   16'h3E00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 13);
    run_op("ovf_rne",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 13);
    run_op("ovf_rtz",     16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 4'b0101, 13);
    run_op("inf_x_zero",  16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000, 1);
    run_op("snan",        16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000, 1);
    run_op("qnan_neg",    16'hFE00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000, 1);
    run_op("qnan_b",      16'h3C00, 16'h7E01, 1'b1, 16'h7E00, 4'b0000, 1);
    run_op("ninf_x_2",    16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'b0000, 1);
    run_op("zero_x_neg",  16'h0000, 16'hC000, 1'b0, 16'h8000, 4'b0000, 1);
    run_op("sub_exact",   16'h0400, 16'h3800, 1'b0, 16'h0200, 4'b0000, 13);
    run_op("sub_tie",     16'h0001, 16'h3800, 1'b0, 16'h0000, 4'b0011, 13);
    run_op("one_x_one",   16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 4'b0000, 13);
    run_op("three_sq",    16'h4200, 16'h4200, 1'b1, 16'h4880, 4'b0000, 13);
    run_op("third_rne",   16'h3555, 16'h4200, 1'b0, 16'h3C00, 4'b0001, 13);
    run_op("third_rtz",   16'h3555, 16'h4200, 1'b1, 16'h3BFF, 4'b0001, 13);

    // Backpressure with a second operation already waiting at the input
    outReady = 1'b0;
    issue("bp_first", 16'hC000, 16'h3C00, 1'b0, 16'hC000, 4'b0000);
    wait_out("bp_first", 13);
    a = 16'h3C00; b = 16'h4000; rm = 1'b0; inValid = 1'b1;
    push_exp("bp_second", 16'h4000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check("bp_hold_result",   32'(result),   32'hC000);
      check("bp_hold_outValid", 32'(outValid), 32'd1);
      check("bp_hold_inReady",  32'(inReady),  32'd0);
    end
    outReady = 1'b1;
    @(posedge clock);
    #1;
    check("hs_inReady",  32'(inReady),  32'd1);
    check("hs_outValid", 32'(outValid), 32'd0);
    @(posedge clock);
    #1;
    check("second_accepted", 32'(inReady), 32'd0);
    inValid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    wait_out("bp_second", 13);
    @(posedge clock);
    #1;
    @(negedge clock);

    // Reset in the middle of the multiply: the operation must vanish
    a = 16'h3E00; b = 16'h4000; rm = 1'b0; inValid = 1'b1;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midrst_outValid", 32'(outValid), 32'd0);
    check("midrst_inReady",  32'(inReady),  32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check("midrst_no_stale", 32'(outValid), 32'd0);
    end
    @(negedge clock);
    run_op("after_rst",   16'h3E00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 13);

    check("sb_empty", 32'(exp_res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
